ssd_scan_ctrl: RTL and testbench

Time-multiplexing controller that shares the 4-digit common-anode seven-segment display between its four digit positions. It holds a double-buffered 16-bit hex/BCD value and scans one digit at a time with a programmable dwell and an anti-ghosting blank gap. It applies optional leading-zero blanking and accepts new display values through a valid/ready handshake. New values take effect only at frame boundaries, so the display never tears. It sits between the FSM/counter logic that produces the value (e.g. the FSM state number) and the board's `int_cathode`/`int_anode` pins.

---
 rtl/ssd_pkg.sv | 29 ++
 rtl/ssd_hex_decode.sv | 37 +++
 rtl/ssd_scan_ctrl.sv | 115 +++++++++++
 tb/tb_ssd_scan_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared segment codes, anode constants and scan state type
package ssd_pkg;

    localparam logic [7:0] SEG_0   = 8'hC0;
    localparam logic [7:0] SEG_1   = 8'hF9;
    localparam logic [7:0] SEG_2   = 8'hA4;
    localparam logic [7:0] SEG_3   = 8'hB0;
    localparam logic [7:0] SEG_4   = 8'h99;
    localparam logic [7:0] SEG_5   = 8'h92;
    localparam logic [7:0] SEG_6   = 8'h82;
    localparam logic [7:0] SEG_7   = 8'hF8;
    localparam logic [7:0] SEG_8   = 8'h80;
    localparam logic [7:0] SEG_9   = 8'h90;
    localparam logic [7:0] SEG_A   = 8'h88;
    localparam logic [7:0] SEG_B   = 8'h83;
    localparam logic [7:0] SEG_C   = 8'hC6;
    localparam logic [7:0] SEG_D   = 8'hA1;
    localparam logic [7:0] SEG_E   = 8'h86;
    localparam logic [7:0] SEG_F   = 8'h8E;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam logic [3:0] ANODE_OFF = 4'hF;

    typedef enum logic {
        BLANK,
        DRIVE
    } scan_state_t;

endpackage

// File: rtl/ssd_hex_decode.sv
// rtl/ssd_hex_decode.sv - hex nibble to active-low seven-segment cathode pattern
module ssd_hex_decode
    import ssd_pkg::*;
(
    input  logic [3:0] value,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] cathode
);

    logic [7:0] seg;

    always_comb begin
        seg = SEG_OFF;
        case (value)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
        // A blanked digit also hides its decimal point
        cathode = blank ? SEG_OFF : (seg & {~dp, 7'h7F});
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// rtl/ssd_scan_ctrl.sv - 4-digit seven-segment scan controller with frame-aligned double buffer
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int DWELL_CYC = 6000,
    parameter int BLANK_CYC = 60
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [15:0] upd_digits,
    input  logic [3:0]  upd_dp,
    input  logic        blank_lz,
    output logic [7:0]  ssd_cathode,
    output logic [3:0]  ssd_anode,
    output logic        frame_tick
);

    localparam int MAX_CYC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    scan_state_t   state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    idx, idx_n;
    logic [15:0]   active_digits, active_digits_n, pend_digits;
    logic [3:0]    active_dp, active_dp_n, pend_dp;
    logic          pend_full;
    logic          at_boundary, accept, lz_blank_n, frame_tick_n;
    logic [3:0]    digit_n;
    logic [7:0]    dec_cathode;

    assign upd_ready = ~pend_full;
    assign accept    = upd_valid & ~pend_full;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt + 1'b1;
        idx_n       = idx;
        at_boundary = (state == DRIVE) && (idx == 2'd3) && (cnt == DWELL_LAST);
        unique case (state)
            BLANK: begin
                if (BLANK_CYC == 0 || cnt == BLANK_LAST) begin
                    state_n = DRIVE;
                    cnt_n   = '0;
                end
            end
            DRIVE: begin
                if (cnt == DWELL_LAST) begin
                    state_n = (BLANK_CYC == 0) ? DRIVE : BLANK;
                    cnt_n   = '0;
                    idx_n   = idx + 1'b1;
                end
            end
        endcase

        // Decode from the post-swap buffer so a zero-gap frame start shows the new value
        active_digits_n = (at_boundary && pend_full) ? pend_digits : active_digits;
        active_dp_n     = (at_boundary && pend_full) ? pend_dp : active_dp;
        digit_n         = active_digits_n[{idx_n, 2'b00} +: 4];

        lz_blank_n = 1'b0;
        case (idx_n)
            2'd0: lz_blank_n = 1'b0;
            2'd1: lz_blank_n = blank_lz && (active_digits_n[15:4] == 12'h000);
            2'd2: lz_blank_n = blank_lz && (active_digits_n[15:8] == 8'h00);
            2'd3: lz_blank_n = blank_lz && (active_digits_n[15:12] == 4'h0);
        endcase

        frame_tick_n = (state_n == DRIVE) && (idx_n == 2'd3) && (cnt_n == DWELL_LAST);
    end

    ssd_hex_decode u_decode (
        .value   (digit_n),
        .dp      (active_dp_n[idx_n]),
        .blank   (lz_blank_n),
        .cathode (dec_cathode)
    );

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state         <= BLANK;
            cnt           <= '0;
            idx           <= 2'd0;
            active_digits <= 16'h0000;
            active_dp     <= 4'h0;
            pend_digits   <= 16'h0000;
            pend_dp       <= 4'h0;
            pend_full     <= 1'b0;
            ssd_anode     <= ANODE_OFF;
            ssd_cathode   <= SEG_OFF;
            frame_tick    <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            idx           <= idx_n;
            active_digits <= active_digits_n;
            active_dp     <= active_dp_n;
            if (at_boundary && pend_full) begin
                pend_full <= 1'b0;
            end
            if (accept) begin
                pend_digits <= upd_digits;
                pend_dp     <= upd_dp;
                pend_full   <= 1'b1;
            end
            ssd_anode   <= (state_n == DRIVE) ? ~(4'b0001 << idx_n) : ANODE_OFF;
            ssd_cathode <= (state_n == DRIVE) ? dec_cathode : SEG_OFF;
            frame_tick  <= frame_tick_n;
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb/tb_ssd_scan_ctrl.sv - self-checking bench for ssd_scan_ctrl
module tb_ssd_scan_ctrl;

    localparam int DWELL = 4;
    localparam int BLANK = 1;
    localparam int SLOT  = DWELL + BLANK;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic        upd_valid = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] upd_digits = 16'h0;
    logic [3:0]  upd_dp = 4'h0;
    logic        upd_ready, frame_tick;
    logic [7:0]  ssd_cathode;
    logic [3:0]  ssd_anode;

    always #5 clk = ~clk;

    ssd_scan_ctrl #(.DWELL_CYC(DWELL), .BLANK_CYC(BLANK)) dut (
        .clk         (clk),
        .clear       (clear),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_digits  (upd_digits),
        .upd_dp      (upd_dp),
        .blank_lz    (blank_lz),
        .ssd_cathode (ssd_cathode),
        .ssd_anode   (ssd_anode),
        .frame_tick  (frame_tick)
    );

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    int n_checks = 0;
    int n_fail = 0;
    int t = 0;
    int boundaries = 0;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_act_dp, m_pend_dp;
    bit          m_full;
    logic [7:0]  cap [4];

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic        lz;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [7:0] exp_cathode(int d, logic [15:0] v, logic [3:0] dp, logic lz);
        logic [15:0] upper;
        logic [3:0]  nib;
        upper = v >> (4 * d);
        nib   = upper[3:0];
        if (lz && d > 0 && upper == 16'h0) return 8'hFF;
        return dp[d] ? (seg_tab[nib] - 8'h80) : seg_tab[nib];
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0d: got %h required %h", name, t, got, exp);
        end
    endtask

    task automatic model_reset();
        t = 0;
        boundaries = 0;
        m_act = 16'h0;
        m_act_dp = 4'h0;
        m_pend = 16'h0;
        m_pend_dp = 4'h0;
        m_full = 1'b0;
    endtask

    // One scan cycle: compare against the frame-position model, drive inputs, advance the model
    task automatic step(bit v, logic [15:0] d, logic [3:0] p, bit lz, output bit acc);
        int pos, slot, off;
        logic [3:0] ea;
        pos  = t % FRAME;
        slot = pos / SLOT;
        off  = pos % SLOT;
        if (off < BLANK) begin
            check("anode_blank", ssd_anode, 4'hF);
            check("cathode_blank", ssd_cathode, 8'hFF);
        end else begin
            ea = 4'hF;
            ea[slot] = 1'b0;
            check("anode_drive", ssd_anode, ea);
            check("cathode_drive", ssd_cathode, exp_cathode(slot, m_act, m_act_dp, blank_lz));
            cap[slot] = ssd_cathode;
        end
        check("frame_tick", frame_tick, (pos == FRAME - 1));
        check("upd_ready", upd_ready, !m_full);
        upd_valid  = v;
        upd_digits = d;
        upd_dp     = p;
        blank_lz   = lz;
        acc = v && !m_full;
        if (pos == FRAME - 1) begin
            boundaries++;
            if (m_full) begin
                m_act    = m_pend;
                m_act_dp = m_pend_dp;
                m_full   = 1'b0;
            end
        end
        if (acc) begin
            m_pend    = d;
            m_pend_dp = p;
            m_full    = 1'b1;
        end
        t++;
        @(negedge clk);
    endtask

    task automatic idle_until(int target_boundaries, bit lz);
        bit a;
        int guard;
        guard = 0;
        while (boundaries < target_boundaries && guard < 4 * FRAME) begin
            step(1'b0, 16'h0, 4'h0, lz, a);
            guard++;
        end
        check("frame_wait", boundaries, target_boundaries);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        clear = 1'b0;
        upd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_anode", ssd_anode, 4'hF);
        check("rst_cathode", ssd_cathode, 8'hFF);
        check("rst_tick", frame_tick, 1'b0);
        check("rst_ready", upd_ready, 1'b1);
        clear = 1'b1;
        model_reset();
    endtask

    task automatic run_vec(vec_t vv);
        bit a;
        int guard, b0;
        a = 1'b0;
        guard = 0;
        while (!a && guard < 3 * FRAME) begin
            step(1'b1, vv.digits, vv.dp, vv.lz, a);
            guard++;
        end
        check("vec_accept", a, 1'b1);
        b0 = boundaries;
        idle_until(b0 + 1, vv.lz);
        for (int i = 0; i < 4; i++) cap[i] = 8'hxx;
        idle_until(b0 + 2, vv.lz);
        for (int i = 0; i < 4; i++) check("vec_digit", cap[i], vv.exp[8*i +: 8]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a, lzr;
        int guard;
        logic [15:0] rd;

        vecs[0] = '{16'h1234, 4'h0, 1'b0, 32'hF9A4B099};
        vecs[1] = '{16'h0042, 4'h0, 1'b1, 32'hFFFF99A4};
        vecs[2] = '{16'h0042, 4'h0, 1'b0, 32'hC0C099A4};
        vecs[3] = '{16'h0000, 4'h0, 1'b1, 32'hFFFFFFC0};
        vecs[4] = '{16'hABCD, 4'b0100, 1'b0, 32'h8803C6A1};
        vecs[5] = '{16'h0005, 4'b1111, 1'b1, 32'hFFFFFF12};
        vecs[6] = '{16'h00F0, 4'b0010, 1'b1, 32'hFFFF0EC0};

        // Back-to-back updates: second one waits for the first boundary
        reset_dut();
        step(1'b1, 16'h0001, 4'h0, 1'b0, a);
        check("bp_first_accept", a, 1'b1);
        step(1'b1, 16'h0002, 4'h0, 1'b0, a);
        check("bp_second_held", a, 1'b0);
        guard = 0;
        while (!a && guard < 3 * FRAME) begin
            step(1'b1, 16'h0002, 4'h0, 1'b0, a);
            guard++;
        end
        check("bp_accept_cycle", t - 1, FRAME);
        for (int i = 0; i < 4; i++) cap[i] = 8'hxx;
        idle_until(2, 1'b0);
        check("bp_frame1_ones", cap[0], 8'hF9);
        check("bp_frame1_thou", cap[3], 8'hC0);
        idle_until(3, 1'b0);
        check("bp_frame2_ones", cap[0], 8'hA4);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Randomized traffic against the frame-position model
        reset_dut();
        lzr = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (t % SLOT == 0) lzr = 1'($urandom_range(0, 1));
            rd = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rd = rd & 16'h000F;
                1: rd = rd & 16'h00FF;
                2: rd = rd & 16'h0FFF;
                default: ;
            endcase
            step(1'($urandom_range(0, 1)), rd, 4'($urandom), lzr, a);
        end

        // Clear while digit 2 is lit, with an update still pending
        reset_dut();
        a = 1'b0;
        guard = 0;
        while (!a && guard < 10) begin
            step(1'b1, 16'h1234, 4'h0, 1'b0, a);
            guard++;
        end
        idle_until(1, 1'b0);
        a = 1'b0;
        guard = 0;
        while (!a && guard < 10) begin
            step(1'b1, 16'h9999, 4'hF, 1'b0, a);
            guard++;
        end
        check("mid_pending_accept", a, 1'b1);
        guard = 0;
        while ((t % FRAME) != 2 * SLOT + 2 && guard < 2 * FRAME) begin
            step(1'b0, 16'h0, 4'h0, 1'b0, a);
            guard++;
        end
        check("mid_digit2_anode", ssd_anode, 4'b1011);
        #2;
        clear = 1'b0;
        #1;
        check("mid_clr_anode", ssd_anode, 4'hF);
        check("mid_clr_cathode", ssd_cathode, 8'hFF);
        check("mid_clr_tick", frame_tick, 1'b0);
        check("mid_clr_ready", upd_ready, 1'b1);
        @(negedge clk);
        clear = 1'b1;
        model_reset();
        for (int i = 0; i < 2 * FRAME; i++) step(1'b0, 16'h0, 4'h0, 1'b0, a);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
